// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive denied host cycles; at_max forces a host grant.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  assign at_max_o = (cnt_q == STARVE_W'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single data-memory port, core priority with host starvation bound.
// Optional statistics outputs enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] conflict_cnt,
  output logic [STAT_W-1:0] host_forced_cnt
`endif
);

  logic   starve_at_max;
  logic   starve_inc;
  logic   host_forced;
  owner_t rd_owner_q;
  owner_t rd_owner_d;

  // Grants are suppressed for the whole time Reset is high.
  always_comb begin
    core_gnt    = 1'b0;
    host_gnt    = 1'b0;
    host_forced = 1'b0;
    if (!Reset) begin
      if (core_req && host_req) begin
        if (starve_at_max) begin
          host_gnt    = 1'b1;
          host_forced = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
    end
  end

  always_comb begin
    mem_en    = core_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign starve_inc = host_req & ~host_gnt;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (~starve_inc),
    .inc_i   (starve_inc),
    .at_max_o(starve_at_max)
  );

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (core_gnt && !core_we) begin
      rd_owner_d = OWN_CORE;
    end else if (host_gnt && !host_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read data is steered to the requester that issued the read one cycle earlier.
  assign core_rvalid = (rd_owner_q == OWN_CORE);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] conflict_q;
  logic [STAT_W-1:0] conflict_d;
  logic [STAT_W-1:0] forced_q;
  logic [STAT_W-1:0] forced_d;

  always_comb begin
    conflict_d = conflict_q;
    forced_d   = forced_q;
    if (core_req && host_req && (conflict_q != '1)) begin
      conflict_d = conflict_q + STAT_W'(1);
    end
    if (host_forced && (forced_q != '1)) begin
      forced_d = forced_q + STAT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      forced_q   <= forced_d;
    end
  end

  assign conflict_cnt    = conflict_q;
  assign host_forced_cnt = forced_q;
`else
  logic unused_forced;
  assign unused_forced = host_forced;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, read scoreboard, reset and starvation sequences.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_req, core_we, host_req, host_we;
  logic [7:0] core_addr, core_wdata, host_addr, host_wdata;
  logic       core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [7:0] core_rdata, host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, host_forced_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int conf_m   = 0;
  int forced_m = 0;

  typedef struct {
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;
    logic       ecg;
    logic       ehg;
  } vec_t;

  typedef struct {
    int         own;
    logic [7:0] data;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [7:0] mem[256];
  logic [7:0] shadow[256];

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(8), .AW(8), .MAX_WAIT(4)) dut (
    .Clk(clk), .Reset(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .host_forced_cnt(host_forced_cnt)
`endif
  );

  // Synchronous memory with one-cycle read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'h5A;
    mem_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic creq, input logic cwe, input logic [7:0] caddr,
                              input logic [7:0] cwd, input logic hreq, input logic hwe,
                              input logic [7:0] haddr, input logic [7:0] hwd,
                              input logic ecg, input logic ehg);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.ecg = ecg; v.ehg = ehg;
    return v;
  endfunction

  task automatic cycle(input vec_t v);
    exp_t e;
    exp_t n;
    logic       e_we;
    logic [7:0] e_addr, e_wd;
    @(negedge clk);
    core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.haddr; host_wdata = v.hwd;
    #1;
    chk("core_gnt", 32'(core_gnt), 32'(v.ecg));
    chk("host_gnt", 32'(host_gnt), 32'(v.ehg));
    chk("mem_en", 32'(mem_en), 32'(v.ecg | v.ehg));
    e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
    if (v.ecg) begin
      e_we = v.cwe; e_addr = v.caddr; e_wd = v.cwd;
    end else if (v.ehg) begin
      e_we = v.hwe; e_addr = v.haddr; e_wd = v.hwd;
    end
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: no expected read entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("core_rvalid", 32'(core_rvalid), 32'(e.own == 1));
      chk("host_rvalid", 32'(host_rvalid), 32'(e.own == 2));
      chk("core_rdata", 32'(core_rdata), (e.own == 1) ? 32'(e.data) : 32'h0);
      chk("host_rdata", 32'(host_rdata), (e.own == 2) ? 32'(e.data) : 32'h0);
    end
    n.own = 0;
    n.data = 8'h00;
    if (v.ecg && !v.cwe) begin
      n.own = 1; n.data = shadow[v.caddr];
    end else if (v.ehg && !v.hwe) begin
      n.own = 2; n.data = shadow[v.haddr];
    end
    sb.push_back(n);
    if (v.ecg && v.cwe) shadow[v.caddr] = v.cwd;
    else if (v.ehg && v.hwe) shadow[v.haddr] = v.hwd;
    if (v.creq && v.hreq) begin
      conf_m++;
      if (v.ehg) forced_m++;
    end
  endtask

  task automatic conflict_run(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(mk(1'b1, 1'b0, 8'(8'h40 + k), 8'h00, 1'b1, 1'b0, 8'h50, 8'h00,
               (k % 5) != 4, (k % 5) == 4));
      chk("starve_bound", 32'(dut.u_starve.cnt_q <= 4'd4), 32'h1);
    end
  endtask

  initial begin
    exp_t idle_e;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;
    shadow[8'h10] = 8'h5A;
    idle_e.own  = 0;
    idle_e.data = 8'h00;

    // Reset held with both requesting: nothing may be granted.
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h11; core_wdata = 8'h22;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h33; host_wdata = 8'h44;
    #1;
    chk("rst_core_gnt", 32'(core_gnt), 32'h0);
    chk("rst_host_gnt", 32'(host_gnt), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid", 32'({core_rvalid, host_rvalid}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    core_req = 1'b0; host_req = 1'b0;
    sb.push_back(idle_e);

    vecs.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0)); // core read 0x10
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1)); // host write
    vecs.push_back(mk(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0)); // core read back
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1)); // host read, no bubble
    vecs.push_back(mk(1, 1, 8'h30, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 8'(8'h40 + k), 8'h00, 1, 0, 8'h50, 8'h00, 1, 0));
    vecs.push_back(mk(1, 1, 8'h60, 8'h99, 1, 0, 8'h50, 8'h00, 0, 1)); // forced host
    vecs.push_back(mk(1, 1, 8'h60, 8'h99, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 8'h60, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0)); // host drop clears wait
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 8'(8'h70 + k), 8'h00, 1, 1, 8'h80, 8'h0F, 1, 0));
    vecs.push_back(mk(1, 0, 8'h74, 8'h00, 1, 1, 8'h80, 8'h0F, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h00, 0, 1));

    foreach (vecs[i]) cycle(vecs[i]);

    conflict_run(10);
    cycle(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(conf_m));
    chk("host_forced_cnt", 32'(host_forced_cnt), 32'(forced_m));
`endif

    // Host read granted, then Reset before the next edge: no rvalid may follow.
    @(negedge clk);
    sb.delete();
    core_req = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    #1;
    chk("pre_rst_host_gnt", 32'(host_gnt), 32'h1);
    #1;
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'({core_gnt, host_gnt}), 32'h0);
    chk("mid_rst_mem", 32'({mem_en, mem_we}), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_host_rdata", 32'(host_rdata), 32'h0);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'h0);
    rst = 1'b0;
    core_req = 1'b0; host_req = 1'b0;
    #1;
    chk("post_rst_outputs", 32'({core_gnt, host_gnt, mem_en, mem_we, core_rvalid, host_rvalid}), 32'h0);
    chk("post_rst_starve", 32'(dut.u_starve.cnt_q), 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("post_rst_conflict", 32'(conflict_cnt), 32'h0);
    chk("post_rst_forced", 32'(host_forced_cnt), 32'h0);
`endif
    sb.push_back(idle_e);

    conflict_run(5);
    cycle(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
